// File: rtl/snake_body_tracker.sv
// Snake segment store: advances the body one cell per accepted step, checks
// wall and self collisions one segment per cycle, and grows on request.
module snake_body_tracker #(
    parameter int MAX_LEN  = 16,
    parameter int IDX_W    = 4,
    parameter int INIT_LEN = 4,
    parameter int X_INIT   = 80,
    parameter int Y_INIT   = 30,
    parameter int STEP     = 10,
    parameter int XSCREEN  = 160,
    parameter int YSCREEN  = 120
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             step_i,
    input  logic [1:0]       dir_i,
    input  logic             grow_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [7:0]       rd_x_o,
    output logic [6:0]       rd_y_o,
    output logic [IDX_W:0]   length_o,
    output logic             alive_o,
    output logic             collision_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    localparam logic [7:0]     X_HI    = 8'(XSCREEN - STEP);
    localparam logic [6:0]     Y_HI    = 7'(YSCREEN - STEP);
    localparam logic [7:0]     STEP_X  = 8'(STEP);
    localparam logic [6:0]     STEP_Y  = 7'(STEP);
    localparam logic [IDX_W:0] LEN_ONE = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] LEN_TWO = (IDX_W+1)'(2);
    localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(MAX_LEN);
    localparam logic [IDX_W:0] LEN_RST = (IDX_W+1)'(INIT_LEN);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DEAD} state_t;

    state_t           state_q;
    logic [7:0]       seg_x_q [MAX_LEN];
    logic [6:0]       seg_y_q [MAX_LEN];
    logic [IDX_W:0]   length_q;
    logic [1:0]       cur_dir_q;
    logic             alive_q;
    logic             collision_q;
    logic             busy_q;
    logic             done_q;
    logic             grow_pend_q;
    logic [7:0]       nh_x_q;
    logic [6:0]       nh_y_q;
    logic [IDX_W-1:0] scan_idx_q;

    logic [1:0]     dir_d;
    logic           wall_d;
    logic [7:0]     nh_x_d;
    logic [6:0]     nh_y_d;
    logic           growing_d;
    logic [IDX_W:0] last_idx_d;
    logic           hit_d;
    logic           scan_last_d;

    // A request for the exact reverse direction is ignored (xor of opposites is 11).
    assign dir_d = ((dir_i ^ cur_dir_q) == 2'b11) ? cur_dir_q : dir_i;

    // Wall compare happens on the current head before the add/sub, so no wrap.
    always_comb begin
        wall_d = 1'b0;
        nh_x_d = seg_x_q[0];
        nh_y_d = seg_y_q[0];
        case (dir_d)
            DIR_RIGHT: begin
                wall_d = (seg_x_q[0] >= X_HI);
                nh_x_d = seg_x_q[0] + STEP_X;
            end
            DIR_DOWN: begin
                wall_d = (seg_y_q[0] >= Y_HI);
                nh_y_d = seg_y_q[0] + STEP_Y;
            end
            DIR_UP: begin
                wall_d = (seg_y_q[0] < STEP_Y);
                nh_y_d = seg_y_q[0] - STEP_Y;
            end
            DIR_LEFT: begin
                wall_d = (seg_x_q[0] < STEP_X);
                nh_x_d = seg_x_q[0] - STEP_X;
            end
            default: ;
        endcase
    end

    // Without growth the tail vacates its cell, so it is excluded from the scan.
    assign growing_d   = grow_pend_q | grow_i;
    assign last_idx_d  = growing_d ? (length_q - LEN_ONE) : (length_q - LEN_TWO);
    assign hit_d       = (seg_x_q[scan_idx_q] == nh_x_q) && (seg_y_q[scan_idx_q] == nh_y_q);
    assign scan_last_d = ({1'b0, scan_idx_q} == last_idx_d);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= 8'(X_INIT);
                seg_y_q[i] <= 7'(Y_INIT + i * STEP);
            end
            state_q     <= S_IDLE;
            length_q    <= LEN_RST;
            cur_dir_q   <= DIR_UP;
            alive_q     <= 1'b1;
            collision_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            grow_pend_q <= 1'b0;
            nh_x_q      <= '0;
            nh_y_q      <= '0;
            scan_idx_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (grow_i && (state_q != S_SHIFT)) begin
                grow_pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (step_i && alive_q) begin
                        cur_dir_q <= dir_d;
                        if (wall_d) begin
                            state_q     <= S_DEAD;
                            alive_q     <= 1'b0;
                            collision_q <= 1'b1;
                            done_q      <= 1'b1;
                        end else begin
                            nh_x_q     <= nh_x_d;
                            nh_y_q     <= nh_y_d;
                            scan_idx_q <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (hit_d) begin
                        state_q     <= S_DEAD;
                        busy_q      <= 1'b0;
                        alive_q     <= 1'b0;
                        collision_q <= 1'b1;
                        done_q      <= 1'b1;
                    end else if (scan_last_d) begin
                        state_q <= S_SHIFT;
                    end else begin
                        scan_idx_q <= scan_idx_q + 1'b1;
                    end
                end
                S_SHIFT: begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_q[i] <= seg_x_q[i-1];
                        seg_y_q[i] <= seg_y_q[i-1];
                    end
                    seg_x_q[0] <= nh_x_q;
                    seg_y_q[0] <= nh_y_q;
                    if (growing_d && (length_q < LEN_MAX)) begin
                        length_q <= length_q + LEN_ONE;
                    end
                    grow_pend_q <= 1'b0;
                    done_q      <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                S_DEAD: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_x_o      = seg_x_q[rd_idx_i];
    assign rd_y_o      = seg_y_q[rd_idx_i];
    assign length_o    = length_q;
    assign alive_o     = alive_q;
    assign collision_o = collision_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Scoreboard bench for snake_body_tracker: a behavioural model predicts each
// move's outcome, latency and body, which is compared when done pulses.
module tb_snake_body_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       step = 1'b0;
    logic [1:0] dir = 2'b00;
    logic       grow = 1'b0;
    logic [3:0] rd_idx = 4'd0;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic [4:0] length;
    logic       alive, collision, busy, done;

    int checks = 0;
    int failures = 0;

    snake_body_tracker dut (
        .clock_i(clk), .reset_i(rst), .step_i(step), .dir_i(dir), .grow_i(grow),
        .rd_idx_i(rd_idx), .rd_x_o(rd_x), .rd_y_o(rd_y), .length_o(length),
        .alive_o(alive), .collision_o(collision), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        int         busy;
        bit         dead;
        logic [7:0] hx;
        logic [6:0] hy;
        int         len;
    } exp_t;

    exp_t sbq[$];

    logic [7:0] mx[16];
    logic [6:0] my[16];
    int         mlen;
    logic [1:0] mdir;
    bit         malive;
    bit         mgp;

    task automatic model_reset();
        mlen = 4; mdir = 2'b10; malive = 1; mgp = 0;
        for (int i = 0; i < 16; i++) begin
            mx[i] = 8'd80;
            my[i] = 7'(30 + i * 10);
        end
        sbq.delete();
    endtask

    task automatic model_step(input logic [1:0] d, input bit g);
        exp_t e;
        int nx, ny, scan, hit;
        bit wall;
        if (g) mgp = 1;
        if (!malive) return;
        if ((d ^ mdir) != 2'b11) mdir = d;
        nx = mx[0]; ny = my[0]; wall = 0;
        case (mdir)
            2'b00: begin wall = (nx >= 150); nx = nx + 10; end
            2'b01: begin wall = (ny >= 110); ny = ny + 10; end
            2'b10: begin wall = (ny < 10);   ny = ny - 10; end
            default: begin wall = (nx < 10); nx = nx - 10; end
        endcase
        e.dead = 0;
        if (wall) begin
            malive = 0; e.dead = 1; e.lat = 1; e.busy = 0;
        end else begin
            scan = mgp ? mlen : mlen - 1;
            hit = -1;
            for (int k = 0; k < scan; k++)
                if (hit < 0 && mx[k] == nx && my[k] == ny) hit = k;
            if (hit >= 0) begin
                malive = 0; e.dead = 1; e.lat = hit + 2; e.busy = hit + 1;
            end else begin
                for (int i = 15; i >= 1; i--) begin
                    mx[i] = mx[i-1]; my[i] = my[i-1];
                end
                mx[0] = 8'(nx); my[0] = 7'(ny);
                if (mgp && mlen < 16) mlen++;
                mgp = 0;
                e.lat = scan + 2; e.busy = scan + 1;
            end
        end
        e.hx = mx[0]; e.hy = my[0]; e.len = mlen;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; step = 0; grow = 0;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic check_segs(input string tag);
        for (int i = 0; i < mlen; i++) begin
            rd_idx = 4'(i);
            #1;
            checks++;
            if (rd_x !== mx[i] || rd_y !== my[i]) begin
                failures++;
                $display("FAIL %s seg%0d: got (%0d,%0d) want (%0d,%0d)", tag, i, rd_x, rd_y, mx[i], my[i]);
            end
        end
    endtask

    task automatic move(input logic [1:0] d, input bit g, input bit poke, output int lat, output int bcnt);
        exp_t e;
        int qn;
        bit got;
        lat = 0; bcnt = 0; got = 0;
        @(negedge clk);
        dir = d; step = 1; grow = g;
        qn = sbq.size();
        model_step(d, g);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin got = 1; lat = n; break; end
            if (busy) bcnt++;
            step = (poke && n == 2);
            grow = 0;
        end
        step = 0; grow = 0;
        if (sbq.size() == qn) begin
            checks++;
            if (got) begin
                failures++;
                $display("FAIL ignored_step: done pulsed after %0d cycles, want no done", lat);
            end
        end else begin
            e = sbq.pop_front();
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL done_timeout: no done within 40 cycles, want at %0d", e.lat);
            end else begin
                checks += 6;
                if (lat != e.lat) begin failures++; $display("FAIL latency: got %0d want %0d", lat, e.lat); end
                if (bcnt != e.busy) begin failures++; $display("FAIL busy_cycles: got %0d want %0d", bcnt, e.busy); end
                if (alive !== !e.dead) begin failures++; $display("FAIL alive: got %0b want %0b", alive, !e.dead); end
                if (collision !== e.dead) begin failures++; $display("FAIL collision: got %0b want %0b", collision, e.dead); end
                if (length !== 5'(e.len)) begin failures++; $display("FAIL length: got %0d want %0d", length, e.len); end
                rd_idx = 4'd0; #1;
                if (rd_x !== e.hx || rd_y !== e.hy) begin
                    failures++;
                    $display("FAIL head: got (%0d,%0d) want (%0d,%0d)", rd_x, rd_y, e.hx, e.hy);
                end
            end
        end
        check_segs("move");
    endtask

    task automatic check_rd(input string tag, input int idx, input int ex, input int ey);
        rd_idx = 4'(idx);
        #1;
        checks++;
        if (rd_x !== 8'(ex) || rd_y !== 7'(ey)) begin
            failures++;
            $display("FAIL %s: got (%0d,%0d) want (%0d,%0d)", tag, rd_x, rd_y, ex, ey);
        end
    endtask

    task automatic check_idle_reset_values(input string tag);
        checks++;
        if (length !== 5'd4 || alive !== 1'b1 || collision !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s: got len=%0d alive=%0b col=%0b busy=%0b done=%0b want 4,1,0,0,0",
                     tag, length, alive, collision, busy, done);
        end
        for (int i = 0; i < 4; i++) check_rd(tag, i, 80, 30 + 10 * i);
    endtask

    task automatic test_reset();
        do_reset();
        check_idle_reset_values("reset");
    endtask

    task automatic test_move_right();
        int lat, b;
        do_reset();
        move(2'b00, 0, 0, lat, b);
        checks += 2;
        if (lat != 5) begin failures++; $display("FAIL t2_latency: got %0d want 5", lat); end
        if (b != 4) begin failures++; $display("FAIL t2_busy: got %0d want 4", b); end
        check_rd("t2_head", 0, 90, 30);
        check_rd("t2_seg1", 1, 80, 30);
        check_rd("t2_seg3", 3, 80, 50);
    endtask

    task automatic test_reverse();
        int lat, b;
        do_reset();
        move(2'b01, 0, 0, lat, b);
        check_rd("t3_head", 0, 80, 20);
        move(2'b01, 0, 0, lat, b);
        check_rd("t3_still_up", 0, 80, 10);
    endtask

    task automatic test_wall();
        int lat, b;
        do_reset();
        for (int i = 0; i < 3; i++) move(2'b10, 0, 0, lat, b);
        check_rd("t4_top", 0, 80, 0);
        move(2'b10, 0, 0, lat, b);
        checks++;
        if (lat != 1 || alive !== 1'b0 || collision !== 1'b1) begin
            failures++;
            $display("FAIL t4_wall: got lat=%0d alive=%0b col=%0b want 1,0,1", lat, alive, collision);
        end
        move(2'b00, 0, 0, lat, b);
        check_rd("t4_dead_head", 0, 80, 0);
    endtask

    task automatic test_grow_self();
        int lat, b;
        do_reset();
        move(2'b00, 1, 0, lat, b);
        checks++;
        if (length !== 5'd5) begin failures++; $display("FAIL t5_len: got %0d want 5", length); end
        check_rd("t5_seg4", 4, 80, 60);
        move(2'b01, 0, 0, lat, b);
        check_rd("t5_head", 0, 90, 40);
        move(2'b11, 0, 0, lat, b);
        checks++;
        if (alive !== 1'b0 || collision !== 1'b1 || lat != 5) begin
            failures++;
            $display("FAIL t5_self: got alive=%0b col=%0b lat=%0d want 0,1,5", alive, collision, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, b;
        do_reset();
        move(2'b00, 0, 1, lat, b);
        move(2'b01, 0, 1, lat, b);
        @(negedge clk); grow = 1; mgp = 1;
        @(negedge clk); grow = 0;
        move(2'b10, 0, 0, lat, b);
        move(2'b11, 0, 1, lat, b);
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        seen = 0;
        @(negedge clk); dir = 2'b00; step = 1;
        @(negedge clk); step = 0;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; seen |= done;
        model_reset();
        check_idle_reset_values("t6_reset_mid");
        for (int n = 0; n < 8; n++) begin @(negedge clk); seen |= done; end
        checks++;
        if (seen) begin failures++; $display("FAIL t6_no_done: got done=1 want 0"); end
    endtask

    task automatic test_max_len();
        int lat, b;
        do_reset();
        for (int i = 0; i < 6; i++) move(2'b00, 1, 0, lat, b);
        for (int i = 0; i < 6; i++) move(2'b01, 1, 0, lat, b);
        checks++;
        if (length !== 5'd16) begin failures++; $display("FAIL t6_len16: got %0d want 16", length); end
        move(2'b01, 1, 0, lat, b);
        checks++;
        if (length !== 5'd16 || alive !== 1'b1) begin
            failures++;
            $display("FAIL t6_len_sat: got len=%0d alive=%0b want 16,1", length, alive);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_move_right();
        test_reverse();
        test_wall();
        test_grow_self();
        test_back_to_back();
        test_reset_mid();
        test_max_len();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
